vita49_unpack: RTL and testbench
================================

// Module: vita49_unpack
// PURPOSE
//  Receive-side VITA-49 IF-data deframer, the counterpart of the TX packer. Consumes 32-bit
//  VITA-49 packets on S_AXIS, checks header/stream ID/sequence, strips prologue and trailer,
//  and forwards payload words on M_AXIS with TLAST on each packet's last payload word.
//  Latches timestamp and trailer for the processor/timing unit; error counters go to status.
// PARAMETERS
//  CHECK_SID   1   1: drop packets whose stream ID != streamID; 0: accept any stream ID
//  CNT_SAT     255 saturation value of each 8-bit error counter
// PORTS
//  AXIS_ACLK      in  1   single clock, all logic on rising edge
//  AXIS_ARESET    in  1   synchronous reset, active-high
//  S_AXIS_TDATA   in  32  packet words in
//  S_AXIS_TVALID  in  1
//  S_AXIS_TLAST   in  1   marks last word of packet
//  S_AXIS_TREADY  out 1
//  M_AXIS_TDATA   out 32  payload words out (registered)
//  M_AXIS_TVALID  out 1
//  M_AXIS_TLAST   out 1   last payload word of packet
//  M_AXIS_TREADY  in  1
//  ctrl           in  32  [0] enable, [1] reset_cmd (level), [2] passthrough
//  streamID       in  32  expected stream identifier
//  status         out 32  {drop_cnt[7:0], seq_err_cnt[7:0], runt_cnt[7:0], last_pkt_cnt[3:0], state[3:0]}
//  timestamp_sec  out 32  TSI of latest accepted packet
//  timestamp_fsec out 64  TSF of latest accepted packet ({word3, word4})
//  ts_valid       out 1   one-cycle pulse when timestamp_* update
//  trailer        out 32  trailer word of latest packet with T=1
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, expect_seq invalid. ctrl/streamID registered one cycle.
//  - Output register slice: S_AXIS_TREADY = ~M_AXIS_TVALID | M_AXIS_TREADY in PAYLOAD/passthrough;
//    constant 1 in HDR/SID/TSI/TSF0/TSF1/TRAIL/DROP; 0 in IDLE. Payload latency 1 cycle; no bubbles
//    at full throughput. M_AXIS_T* stable while TVALID & ~TREADY.
//  - passthrough=1: every S word forwarded as-is with its TLAST; parser state held; no counters.
//  - Word counter wcnt (16b) counts accepted S words of current packet, header = word 0.
//  - States: IDLE -> HDR (enable) ; HDR -> SID ; SID -> TSI ; TSI -> TSF0 ; TSF0 -> TSF1 ;
//    TSF1 -> PAYLOAD ; PAYLOAD -> TRAIL (T=1 and wcnt+2==size) | HDR/IDLE (wcnt+1==size) ;
//    TRAIL -> HDR, or IDLE if enable=0 ; any -> DROP on error ; DROP -> HDR/IDLE after TLAST word.
//  - HDR checks: [31:28]==4'b0001, [23:22]==2'b11, [21:20]==2'b01, size=[15:0] >= 6+T; else DROP,
//    drop_cnt++. T=[26]; seq=[19:16] latched.
//  - SID: if CHECK_SID and word != streamID -> DROP, drop_cnt++.
//  - Sequence: if expect_seq valid and seq != expect_seq, seq_err_cnt++ (packet still accepted);
//    expect_seq <= seq+1 (mod 16) for every accepted packet. last_pkt_cnt = seq.
//  - TSF1 accept: timestamp_sec/fsec load, ts_valid pulses next cycle.
//  - PAYLOAD: word forwarded; M_AXIS_TLAST=1 on last payload word (wcnt+1==size, or +2 with T).
//  - Runt: S_TLAST before expected end. In PAYLOAD: forward word with M_TLAST=1, runt_cnt++, -> HDR.
//    In prologue states: runt_cnt++, nothing forwarded, -> HDR. Packet with 0 payload words never
//    emits a data beat.
//  - Long packet: expected end reached without S_TLAST: runt_cnt++, -> DROP (rest discarded).
//  - TRAIL: trailer <= word; if S_TLAST absent, -> DROP as long packet.
//  - Counters saturate at CNT_SAT, never wrap.
//  - reset_cmd: counters cleared, expect_seq invalid, output slice flushed; state -> DROP if
//    wcnt!=0 (resync at next TLAST) else IDLE. Held while reset_cmd=1.
//  - enable=0 mid-packet: current packet completes, then IDLE.
// TESTING
//  1 Packet size=10, T=0, sid match, 5 payload words 0x1..0x5, M_TREADY=1 -> 5 beats, TLAST on 0x5,
//    timestamp_sec/fsec = words 2/3-4, ts_valid one pulse, counters 0.
//  2 Size=10, T=1, trailer 0xCAFE0001 -> 4 payload beats, TLAST on 4th, trailer=0xCAFE0001.
//  3 Three packets seq 0,1,3 -> seq_err_cnt=1; header type 0x4 -> drop_cnt=1, no M beats.
//  4 Size=10 but S_TLAST on word 7 -> beats words 5-7, TLAST on word 7, runt_cnt=1; next packet OK.
//  5 Random M_TREADY 30% with back-to-back packets -> payload order/TLAST exact, no loss/duplication.
//  6 reset_cmd pulse mid-payload -> counters 0, M_TVALID 0, rest dropped to TLAST, next packet OK.

Source files
------------

// File: rtl/vita49_unpack.sv
// VITA-49 IF-data deframer: checks the prologue, strips header/timestamps/trailer and forwards
// payload words through a one-deep output register slice.
module vita49_unpack #(
   parameter bit          CHECK_SID = 1'b1,
   parameter int unsigned CNT_SAT   = 255
) (
   input  logic        AXIS_ACLK,
   input  logic        AXIS_ARESET,
   input  logic [31:0] S_AXIS_TDATA,
   input  logic        S_AXIS_TVALID,
   input  logic        S_AXIS_TLAST,
   output logic        S_AXIS_TREADY,
   output logic [31:0] M_AXIS_TDATA,
   output logic        M_AXIS_TVALID,
   output logic        M_AXIS_TLAST,
   input  logic        M_AXIS_TREADY,
   input  logic [31:0] ctrl,
   input  logic [31:0] streamID,
   output logic [31:0] status,
   output logic [31:0] timestamp_sec,
   output logic [63:0] timestamp_fsec,
   output logic        ts_valid,
   output logic [31:0] trailer
);

   typedef enum logic [3:0] {
      StIdle, StHdr, StSid, StTsi, StTsf0, StTsf1, StPayload, StTrail, StDrop
   } state_e;

   localparam logic [7:0] SatVal = 8'(CNT_SAT);

   state_e      state_q, state_d;
   logic [15:0] wcnt_q, wcnt_d, size_q, size_d;
   logic        t_q, t_d;
   logic [3:0]  seq_q, seq_d, exp_seq_q, exp_seq_d, last_seq_q, last_seq_d;
   logic        exp_vld_q, exp_vld_d;
   logic [7:0]  drop_q, drop_d, seqe_q, seqe_d, runt_q, runt_d;
   logic [31:0] tsi_q, tsi_d, tsf0_q, tsf0_d, ts_sec_q, ts_sec_d, trailer_q, trailer_d;
   logic [63:0] ts_fsec_q, ts_fsec_d;
   logic        ts_vld_q, ts_vld_d;
   logic [31:0] m_data_q, m_data_d;
   logic        m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic [2:0]  ctrl_q;
   logic [31:0] sid_q;

   logic   enable, rst_cmd, pass, slice_rdy, s_ready, s_fire, last_exp, hdr_ok;
   state_e start_st;
   logic   unused_ctrl;

   assign unused_ctrl = ^ctrl[31:3];
   assign enable      = ctrl_q[0];
   assign rst_cmd     = ctrl_q[1];
   assign pass        = ctrl_q[2];
   assign slice_rdy   = ~m_valid_q | M_AXIS_TREADY;
   assign s_fire      = S_AXIS_TVALID & s_ready;
   assign start_st    = enable ? StHdr : StIdle;
   // Last payload word sits one before the trailer when T=1.
   assign last_exp    = t_q ? (wcnt_q + 16'd2 == size_q) : (wcnt_q + 16'd1 == size_q);
   assign hdr_ok      = (S_AXIS_TDATA[31:28] == 4'b0001) && (S_AXIS_TDATA[23:22] == 2'b11) &&
                        (S_AXIS_TDATA[21:20] == 2'b01) &&
                        (S_AXIS_TDATA[15:0] >= 16'd6 + {15'd0, S_AXIS_TDATA[26]});

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == SatVal) ? c : c + 8'd1;
   endfunction

   // Input ready: slice-limited when forwarding, always open while parsing/dropping.
   always_comb begin
      s_ready = 1'b1;
      if (pass) begin
         s_ready = slice_rdy;
      end else begin
         case (state_q)
            StIdle:    s_ready = 1'b0;
            StPayload: s_ready = slice_rdy;
            default:   s_ready = 1'b1;
         endcase
      end
   end

   // Parser next state, counters, latched fields and output slice.
   always_comb begin
      state_d    = state_q;   wcnt_d    = wcnt_q;    size_d    = size_q;
      t_d        = t_q;       seq_d     = seq_q;     exp_seq_d = exp_seq_q;
      exp_vld_d  = exp_vld_q; last_seq_d = last_seq_q;
      drop_d     = drop_q;    seqe_d    = seqe_q;    runt_d    = runt_q;
      tsi_d      = tsi_q;     tsf0_d    = tsf0_q;    ts_sec_d  = ts_sec_q;
      ts_fsec_d  = ts_fsec_q; ts_vld_d  = 1'b0;      trailer_d = trailer_q;
      m_data_d   = m_data_q;  m_last_d  = m_last_q;
      m_valid_d  = m_valid_q & ~M_AXIS_TREADY;

      if (rst_cmd) begin
         drop_d = '0; seqe_d = '0; runt_d = '0; last_seq_d = '0;
         exp_vld_d = 1'b0;
         m_valid_d = 1'b0;
         if (s_fire) wcnt_d = S_AXIS_TLAST ? 16'd0 : wcnt_q + 16'd1;
         // Mid-packet: resync on the next TLAST.
         state_d = (wcnt_d != 16'd0) ? StDrop : StIdle;
      end else if (pass) begin
         if (s_fire) begin
            m_valid_d = 1'b1; m_data_d = S_AXIS_TDATA; m_last_d = S_AXIS_TLAST;
         end
      end else begin
         if (s_fire) wcnt_d = S_AXIS_TLAST ? 16'd0 : wcnt_q + 16'd1;
         case (state_q)
            StIdle: if (enable) state_d = StHdr;
            StHdr: begin
               if (s_fire) begin
                  size_d = S_AXIS_TDATA[15:0];
                  t_d    = S_AXIS_TDATA[26];
                  seq_d  = S_AXIS_TDATA[19:16];
                  if (!hdr_ok) begin
                     drop_d  = sat_inc(drop_q);
                     state_d = S_AXIS_TLAST ? start_st : StDrop;
                  end else if (S_AXIS_TLAST) begin
                     runt_d  = sat_inc(runt_q);
                     state_d = start_st;
                  end else begin
                     state_d = StSid;
                  end
               end else if (!enable) begin
                  state_d = StIdle;
               end
            end
            StSid: if (s_fire) begin
               if (CHECK_SID && (S_AXIS_TDATA != sid_q)) begin
                  drop_d  = sat_inc(drop_q);
                  state_d = S_AXIS_TLAST ? start_st : StDrop;
               end else begin
                  if (exp_vld_q && (seq_q != exp_seq_q)) seqe_d = sat_inc(seqe_q);
                  exp_seq_d  = seq_q + 4'd1;
                  exp_vld_d  = 1'b1;
                  last_seq_d = seq_q;
                  if (S_AXIS_TLAST) begin
                     runt_d = sat_inc(runt_q); state_d = start_st;
                  end else begin
                     state_d = StTsi;
                  end
               end
            end
            StTsi: if (s_fire) begin
               tsi_d = S_AXIS_TDATA;
               if (S_AXIS_TLAST) begin
                  runt_d = sat_inc(runt_q); state_d = start_st;
               end else begin
                  state_d = StTsf0;
               end
            end
            StTsf0: if (s_fire) begin
               tsf0_d = S_AXIS_TDATA;
               if (S_AXIS_TLAST) begin
                  runt_d = sat_inc(runt_q); state_d = start_st;
               end else begin
                  state_d = StTsf1;
               end
            end
            StTsf1: if (s_fire) begin
               if (S_AXIS_TLAST) begin
                  runt_d = sat_inc(runt_q); state_d = start_st;
               end else begin
                  ts_sec_d  = tsi_q;
                  ts_fsec_d = {tsf0_q, S_AXIS_TDATA};
                  ts_vld_d  = 1'b1;
                  state_d   = StPayload;
               end
            end
            StPayload: if (s_fire) begin
               m_valid_d = 1'b1;
               m_data_d  = S_AXIS_TDATA;
               m_last_d  = S_AXIS_TLAST | last_exp;
               if (S_AXIS_TLAST) begin
                  // TLAST anywhere but the true end (incl. missing trailer) is a runt.
                  if (!(last_exp && !t_q)) runt_d = sat_inc(runt_q);
                  state_d = start_st;
               end else if (last_exp) begin
                  if (t_q) begin
                     state_d = StTrail;
                  end else begin
                     runt_d  = sat_inc(runt_q);
                     state_d = StDrop;
                  end
               end
            end
            StTrail: if (s_fire) begin
               trailer_d = S_AXIS_TDATA;
               if (S_AXIS_TLAST) begin
                  state_d = start_st;
               end else begin
                  runt_d  = sat_inc(runt_q);
                  state_d = StDrop;
               end
            end
            StDrop: if (s_fire && S_AXIS_TLAST) state_d = start_st;
            default: state_d = StIdle;
         endcase
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge AXIS_ACLK) begin
      if (AXIS_ARESET) begin
         state_q   <= StIdle; wcnt_q    <= '0; size_q    <= '0; t_q        <= 1'b0;
         seq_q     <= '0;     exp_seq_q <= '0; exp_vld_q <= 1'b0; last_seq_q <= '0;
         drop_q    <= '0;     seqe_q    <= '0; runt_q    <= '0;
         tsi_q     <= '0;     tsf0_q    <= '0; ts_sec_q  <= '0; ts_fsec_q  <= '0;
         ts_vld_q  <= 1'b0;   trailer_q <= '0;
         m_data_q  <= '0;     m_valid_q <= 1'b0; m_last_q <= 1'b0;
         ctrl_q    <= '0;     sid_q     <= '0;
      end else begin
         state_q   <= state_d;   wcnt_q    <= wcnt_d;    size_q    <= size_d;
         t_q       <= t_d;       seq_q     <= seq_d;     exp_seq_q <= exp_seq_d;
         exp_vld_q <= exp_vld_d; last_seq_q <= last_seq_d;
         drop_q    <= drop_d;    seqe_q    <= seqe_d;    runt_q    <= runt_d;
         tsi_q     <= tsi_d;     tsf0_q    <= tsf0_d;    ts_sec_q  <= ts_sec_d;
         ts_fsec_q <= ts_fsec_d; ts_vld_q  <= ts_vld_d;  trailer_q <= trailer_d;
         m_data_q  <= m_data_d;  m_valid_q <= m_valid_d; m_last_q  <= m_last_d;
         ctrl_q    <= ctrl[2:0]; sid_q     <= streamID;
      end
   end

   assign S_AXIS_TREADY  = s_ready;
   assign M_AXIS_TDATA   = m_data_q;
   assign M_AXIS_TVALID  = m_valid_q;
   assign M_AXIS_TLAST   = m_last_q;
   assign status         = {drop_q, seqe_q, runt_q, last_seq_q, state_q};
   assign timestamp_sec  = ts_sec_q;
   assign timestamp_fsec = ts_fsec_q;
   assign ts_valid       = ts_vld_q;
   assign trailer        = trailer_q;

endmodule

// File: tb/tb_vita49_unpack.sv
// Bench for vita49_unpack: table of directed packets plus reset_cmd and back-pressure sequences.
module tb_vita49_unpack;

   localparam logic [31:0] SID = 32'h0000_ABCD;

   typedef struct packed {
      logic [3:0]  ptype;
      logic        t;
      logic [3:0]  seq;
      logic [15:0] size;
      logic        sid_ok;
      logic [7:0]  nw;
      logic [7:0]  beats;
      logic [7:0]  drop;
      logic [7:0]  seqe;
      logic [7:0]  runt;
      logic        ts;
      logic        trl;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] S_TDATA;
   logic        S_TVALID, S_TLAST, S_TREADY;
   logic [31:0] M_TDATA;
   logic        M_TVALID, M_TLAST;
   logic        M_TREADY = 1'b1;
   logic [31:0] ctrl;
   logic [31:0] status, timestamp_sec, trailer;
   logic [63:0] timestamp_fsec;
   logic        ts_valid;

   int    n_chk = 0, n_pass = 0;
   int    rdy_mode = 0;
   int    ts_total = 0;
   int    stall_err = 0;
   bit    aborted = 1'b0;
   beat_t got_q[$];
   logic  prev_stall = 1'b0;
   beat_t prev_beat;
   vec_t  vecs[15];

   vita49_unpack #(.CHECK_SID(1'b1), .CNT_SAT(255)) dut (
      .AXIS_ACLK      (clk),
      .AXIS_ARESET    (rst),
      .S_AXIS_TDATA   (S_TDATA),
      .S_AXIS_TVALID  (S_TVALID),
      .S_AXIS_TLAST   (S_TLAST),
      .S_AXIS_TREADY  (S_TREADY),
      .M_AXIS_TDATA   (M_TDATA),
      .M_AXIS_TVALID  (M_TVALID),
      .M_AXIS_TLAST   (M_TLAST),
      .M_AXIS_TREADY  (M_TREADY),
      .ctrl           (ctrl),
      .streamID       (SID),
      .status         (status),
      .timestamp_sec  (timestamp_sec),
      .timestamp_fsec (timestamp_fsec),
      .ts_valid       (ts_valid),
      .trailer        (trailer)
   );

   always #5 clk = ~clk;

   // Output ready pattern changes just after the edge: 0 always ready, 1 random 30%, 2 stalled.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1:       M_TREADY = ($urandom_range(0, 99) < 30);
         2:       M_TREADY = 1'b0;
         default: M_TREADY = 1'b1;
      endcase
   end

   // Beat collector and stall-stability monitor.
   always @(negedge clk) begin
      if (M_TVALID && M_TREADY) got_q.push_back({M_TDATA, M_TLAST});
      if (ts_valid) ts_total <= ts_total + 1;
      if (rdy_mode == 1 && prev_stall && ({M_TVALID, M_TDATA, M_TLAST} != {1'b1, prev_beat}))
         stall_err <= stall_err + 1;
      prev_stall <= M_TVALID && !M_TREADY;
      prev_beat  <= {M_TDATA, M_TLAST};
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mkv(input int ptype, input int t, input int seq, input int size,
                                input int sid_ok, input int nw, input int beats, input int drop,
                                input int seqe, input int runt, input int ts, input int trl);
      vec_t v;
      v.ptype = 4'(ptype); v.t = 1'(t); v.seq = 4'(seq); v.size = 16'(size);
      v.sid_ok = 1'(sid_ok); v.nw = 8'(nw); v.beats = 8'(beats); v.drop = 8'(drop);
      v.seqe = 8'(seqe); v.runt = 8'(runt); v.ts = 1'(ts); v.trl = 1'(trl);
      return v;
   endfunction

   function automatic logic [31:0] word_of(input vec_t v, input int i, input int k);
      logic [7:0] ib;
      ib = 8'(i);
      if (k == 0) return {v.ptype, 1'b0, v.t, 2'b00, 2'b11, 2'b01, v.seq, v.size};
      if (k == 1) return v.sid_ok ? SID : ~SID;
      if (k == 2) return {24'h5EC000, ib};
      if (k == 3) return {24'hF00000, ib};
      if (k == 4) return {24'h0A0000, ib};
      if (v.t && k == int'(v.size) - 1) return {24'hCAFE00, ib};
      return {8'hD0, ib, 16'(k)};
   endfunction

   task automatic send_word(input logic [31:0] d, input logic l);
      int guard = 0;
      if (aborted) return;
      S_TDATA = d; S_TVALID = 1'b1; S_TLAST = l;
      while (!S_TREADY && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (!S_TREADY) begin
         n_chk++;
         aborted = 1'b1;
         $display("FAIL s_ready timeout: word 0x%0h not accepted, ready=%0b required 1", d,
                  S_TREADY);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      S_TVALID = 1'b0; S_TLAST = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int i);
      string tag;
      int    base, ts0;
      tag  = $sformatf("v%0d", i);
      base = got_q.size();
      ts0  = ts_total;
      for (int k = 0; k < int'(v.nw); k++) send_word(word_of(v, i, k), k == int'(v.nw) - 1);
      drain();
      check({tag, " beats"}, 64'(got_q.size() - base), 64'(v.beats));
      for (int b = 0; b < int'(v.beats) && base + b < got_q.size(); b++)
         check($sformatf("%s beat%0d", tag, b), 64'(got_q[base + b]),
               64'({word_of(v, i, 5 + b), b == int'(v.beats) - 1}));
      check({tag, " drop_cnt"}, 64'(status[31:24]), 64'(v.drop));
      check({tag, " seq_err_cnt"}, 64'(status[23:16]), 64'(v.seqe));
      check({tag, " runt_cnt"}, 64'(status[15:8]), 64'(v.runt));
      check({tag, " ts_valid pulses"}, 64'(ts_total - ts0), 64'(v.ts));
      if (v.ts) begin
         check({tag, " ts_sec"}, 64'(timestamp_sec), 64'(word_of(v, i, 2)));
         check({tag, " ts_fsec"}, timestamp_fsec, {word_of(v, i, 3), word_of(v, i, 4)});
      end
      if (v.trl) check({tag, " trailer"}, 64'(trailer), 64'(word_of(v, i, int'(v.size) - 1)));
   endtask

   initial begin
      vec_t      r;
      beat_t     exp_q[$];
      int        base, guard;

      //              ty T seq sz sid nw  bt dr se ru ts trl
      vecs[0]  = mkv(1, 0, 0, 10, 1, 10, 5, 0, 0, 0, 1, 0);
      vecs[1]  = mkv(1, 1, 1, 10, 1, 10, 4, 0, 0, 0, 1, 1);
      vecs[2]  = mkv(1, 0, 3,  8, 1,  8, 3, 0, 1, 0, 1, 0);
      vecs[3]  = mkv(4, 0, 4, 10, 1, 10, 0, 1, 1, 0, 0, 0);
      vecs[4]  = mkv(1, 0, 4, 10, 1,  8, 3, 1, 1, 1, 1, 0);
      vecs[5]  = mkv(1, 0, 5, 10, 1, 10, 5, 1, 1, 1, 1, 0);
      vecs[6]  = mkv(1, 0, 6, 10, 0, 10, 0, 2, 1, 1, 0, 0);
      vecs[7]  = mkv(1, 0, 6,  6, 1,  6, 1, 2, 1, 1, 1, 0);
      vecs[8]  = mkv(1, 0, 7,  8, 1, 11, 3, 2, 1, 2, 1, 0);
      vecs[9]  = mkv(1, 0, 8, 10, 1,  3, 0, 2, 1, 3, 0, 0);
      vecs[10] = mkv(1, 1, 9, 10, 1,  9, 4, 2, 1, 4, 1, 0);
      vecs[11] = mkv(1, 1, 10, 10, 1, 11, 4, 2, 1, 5, 1, 1);
      vecs[12] = mkv(1, 0, 11, 10, 1, 10, 5, 2, 1, 5, 1, 0);
      vecs[13] = mkv(1, 0, 12,  5, 1, 10, 0, 3, 1, 5, 0, 0);
      vecs[14] = mkv(1, 1, 12,  7, 1,  7, 1, 3, 1, 5, 1, 1);

      rst = 1'b1; ctrl = 32'd0; S_TVALID = 1'b0; S_TLAST = 1'b0; S_TDATA = 32'd0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset status", 64'(status), 64'd0);
      check("reset m_valid", 64'(M_TVALID), 64'd0);
      check("reset s_ready idle", 64'(S_TREADY), 64'd0);
      check("reset ts_sec", 64'(timestamp_sec), 64'd0);
      check("reset trailer", 64'(trailer), 64'd0);

      ctrl = 32'd1;
      @(negedge clk);
      for (int i = 0; i < 15; i++) run_vec(vecs[i], i);
      check("last_pkt_cnt", 64'(status[7:4]), 64'd12);
      check("state hdr", 64'(status[3:0]), 64'd1);

      // reset_cmd while a payload beat is stuck in the output slice.
      r = mkv(1, 0, 13, 10, 1, 10, 0, 0, 0, 0, 0, 0);
      rdy_mode = 2;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 6; k++) send_word(word_of(r, 15, k), 1'b0);
      S_TVALID = 1'b0;
      repeat (2) @(negedge clk);
      check("rc beat held", 64'(M_TVALID), 64'd1);
      ctrl = 32'd3;
      repeat (3) @(negedge clk);
      ctrl = 32'd1;
      repeat (2) @(negedge clk);
      check("rc m_valid flushed", 64'(M_TVALID), 64'd0);
      check("rc counters", 64'(status[31:8]), 64'd0);
      rdy_mode = 0;
      @(negedge clk);
      base = got_q.size();
      for (int k = 6; k < 10; k++) send_word(word_of(r, 15, k), k == 9);
      drain();
      check("rc rest dropped", 64'(got_q.size() - base), 64'd0);
      check("rc state hdr", 64'(status[3:0]), 64'd1);
      run_vec(mkv(1, 0, 0, 10, 1, 10, 5, 0, 0, 0, 1, 0), 16);

      // Back-to-back packets under random back-pressure.
      rdy_mode = 1;
      base = got_q.size();
      for (int p = 0; p < 6; p++) begin
         r = mkv(1, p % 2, p + 1, 8 + (p % 3), 1, 8 + (p % 3), 0, 0, 0, 0, 0, 0);
         for (int k = 5; k < int'(r.size) - int'(r.t); k++)
            exp_q.push_back({word_of(r, 20 + p, k), k == int'(r.size) - int'(r.t) - 1});
         for (int k = 0; k < int'(r.nw); k++) send_word(word_of(r, 20 + p, k), k == int'(r.nw) - 1);
      end
      S_TVALID = 1'b0; S_TLAST = 1'b0;
      guard = 0;
      while (got_q.size() - base < exp_q.size() && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      check("bp beat count", 64'(got_q.size() - base), 64'(exp_q.size()));
      for (int b = 0; b < exp_q.size() && base + b < got_q.size(); b++)
         check($sformatf("bp beat%0d", b), 64'(got_q[base + b]), 64'(exp_q[b]));
      check("bp stall stability", 64'(stall_err), 64'd0);
      rdy_mode = 0;
      repeat (4) @(negedge clk);
      check("bp counters", 64'(status[31:8]), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
